// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared constants for the pipeline stall/flush controller
package pipe_ctrl_pkg;
  localparam logic [1:0]  RUN         = 2'd0;
  localparam logic [1:0]  WAIT        = 2'd1;
  localparam logic [1:0]  ERROR       = 2'd2;
  localparam logic [31:0] NOP_INSTR   = 32'h00000013;
  localparam logic [7:0]  BUBBLE_CTRL = 8'h00;

  typedef struct packed {
    logic pc;
    logic if_id;
    logic id_ex;
    logic ex_mem;
    logic mem_wb;
  } stage_we_t;

  typedef struct packed {
    logic if_id;
    logic id_ex;
    logic mem_wb;
  } stage_flush_t;

  localparam stage_we_t    WE_ALL   = 5'b11111;
  localparam stage_we_t    WE_NONE  = 5'b00000;
  localparam stage_flush_t FL_NONE  = 3'b000;
endpackage

// File: rtl/pipeline_ctrl_if.sv
// rtl/pipeline_ctrl_if.sv - hazard inputs, dmem handshake and stage controls
interface pipeline_ctrl_if;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_uses_rs1;
  logic       id_uses_rs2;
  logic [4:0] ex_rd;
  logic       ex_mem_read;
  logic       ex_branch_taken;
  logic       mem_access;
  logic       dmem_ready;
  logic       dmem_valid;
  logic       pc_we;
  logic       if_id_we;
  logic       id_ex_we;
  logic       ex_mem_we;
  logic       mem_wb_we;
  logic       if_id_flush;
  logic       id_ex_flush;
  logic       mem_wb_flush;

  modport master (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
           ex_branch_taken, mem_access, dmem_ready,
    output dmem_valid, pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
           if_id_flush, id_ex_flush, mem_wb_flush
  );

  modport slave (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_read,
           ex_branch_taken, mem_access, dmem_ready,
    input  dmem_valid, pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
           if_id_flush, id_ex_flush, mem_wb_flush
  );
endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// rtl/pipeline_ctrl_hazard_detect.sv - load-use comparator between EX load and ID sources
module hazard_detect (
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_mem_read,
  output logic       load_use
);
  // x0 is hardwired zero, so a load targeting it never creates a dependency
  assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                    ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                     (id_uses_rs2 && (id_rs2 == ex_rd)));
endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - stall/flush controller for the 5-stage RV32I pipeline
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  pipeline_ctrl_if.master  pif,
  output logic             err,
  output logic [CNT_W-1:0] stall_cnt
);
  localparam int WCW = $clog2(MAX_WAIT + 1);

  logic [1:0]       state_q, state_d;
  logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             load_use;
  logic             mem_wait;
  stage_we_t        we;
  stage_flush_t     fl;

  hazard_detect u_hazard_detect (
    .id_rs1      (pif.id_rs1),
    .id_rs2      (pif.id_rs2),
    .id_uses_rs1 (pif.id_uses_rs1),
    .id_uses_rs2 (pif.id_uses_rs2),
    .ex_rd       (pif.ex_rd),
    .ex_mem_read (pif.ex_mem_read),
    .load_use    (load_use)
  );

  assign mem_wait = ((state_q == RUN) && pif.mem_access && !pif.dmem_ready) ||
                    ((state_q == WAIT) && !pif.dmem_ready);

  always_comb begin
    we         = WE_ALL;
    fl         = FL_NONE;
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    if (state_q == ERROR) begin
      we = WE_NONE;
    end else if (mem_wait) begin
      // Freeze everything and drain MEM/WB; EX/ID hazards re-evaluate on release
      we        = WE_NONE;
      fl.mem_wb = 1'b1;
      if (state_q == RUN) begin
        state_d    = WAIT;
        wait_cnt_d = WCW'(1);
      end else if (wait_cnt_q == WCW'(MAX_WAIT - 1)) begin
        state_d = ERROR;
      end else begin
        wait_cnt_d = wait_cnt_q + WCW'(1);
      end
    end else begin
      if (state_q == WAIT) begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
      if (pif.ex_branch_taken) begin
        fl.if_id = 1'b1;
        fl.id_ex = 1'b1;
      end else if (load_use) begin
        we.pc    = 1'b0;
        we.if_id = 1'b0;
        fl.id_ex = 1'b1;
      end
    end
    if (reset) begin
      we = WE_ALL;
      fl = FL_NONE;
    end
    stall_cnt_d = stall_cnt_q;
    if (!we.pc && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign pif.pc_we        = we.pc;
  assign pif.if_id_we     = we.if_id;
  assign pif.id_ex_we     = we.id_ex;
  assign pif.ex_mem_we    = we.ex_mem;
  assign pif.mem_wb_we    = we.mem_wb;
  assign pif.if_id_flush  = fl.if_id;
  assign pif.id_ex_flush  = fl.id_ex;
  assign pif.mem_wb_flush = fl.mem_wb;
  assign pif.dmem_valid   = pif.mem_access && (state_q != ERROR);
  assign err              = (state_q == ERROR);
  assign stall_cnt        = stall_cnt_q;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - directed self-checking bench for pipeline_ctrl
module tb_pipeline_ctrl;
  logic       clk;
  logic       reset;
  logic       err;
  logic [3:0] stall_cnt;
  int         nerr;
  int         nchk;

  pipeline_ctrl_if pif ();

  pipeline_ctrl #(.MAX_WAIT(16), .CNT_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .pif       (pif),
    .err       (err),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] we_vec();
    return {pif.pc_we, pif.if_id_we, pif.id_ex_we, pif.ex_mem_we, pif.mem_wb_we};
  endfunction

  function automatic logic [2:0] fl_vec();
    return {pif.if_id_flush, pif.id_ex_flush, pif.mem_wb_flush};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    pif.id_rs1 = 5'd0; pif.id_rs2 = 5'd0;
    pif.id_uses_rs1 = 1'b0; pif.id_uses_rs2 = 1'b0;
    pif.ex_rd = 5'd0; pif.ex_mem_read = 1'b0; pif.ex_branch_taken = 1'b0;
    pif.mem_access = 1'b0; pif.dmem_ready = 1'b0;
  endtask

  initial begin
    nerr = 0;
    nchk = 0;
    clear_inputs();
    reset = 1'b1;
    pif.mem_access = 1'b1;
    #2;
    check("rst_we", 32'(we_vec()), 32'h1F);
    check("rst_fl", 32'(fl_vec()), 32'h0);
    tick();
    check("rst_stall", 32'(stall_cnt), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    reset = 1'b0;
    clear_inputs();
    #1;
    check("idle_we", 32'(we_vec()), 32'h1F);

    // load x5 in EX, ID reads x5 via rs1
    tick();
    pif.ex_mem_read = 1'b1; pif.ex_rd = 5'd5; pif.id_rs1 = 5'd5; pif.id_uses_rs1 = 1'b1;
    #1;
    check("lu_rs1_we", 32'(we_vec()), 32'h07);
    check("lu_rs1_fl", 32'(fl_vec()), 32'h2);
    tick();
    clear_inputs();
    #1;
    check("lu_rs1_release_we", 32'(we_vec()), 32'h1F);
    check("lu_rs1_stall", 32'(stall_cnt), 32'd1);

    // rs2 match stalls; rs1 match without use flag does not
    pif.ex_mem_read = 1'b1; pif.ex_rd = 5'd7; pif.id_rs1 = 5'd7; pif.id_rs2 = 5'd7;
    pif.id_uses_rs2 = 1'b1;
    #1;
    check("lu_rs2_we", 32'(we_vec()), 32'h07);
    tick();
    pif.id_uses_rs2 = 1'b0;
    #1;
    check("lu_unused_we", 32'(we_vec()), 32'h1F);
    check("lu_rs2_stall", 32'(stall_cnt), 32'd2);

    // load to x0 never stalls
    pif.ex_rd = 5'd0; pif.id_rs1 = 5'd0; pif.id_uses_rs1 = 1'b1;
    #1;
    check("x0_we", 32'(we_vec()), 32'h1F);
    check("x0_fl", 32'(fl_vec()), 32'h0);

    // taken branch overrides a load-use match
    tick();
    pif.ex_rd = 5'd5; pif.id_rs1 = 5'd5; pif.ex_branch_taken = 1'b1;
    #1;
    check("br_lu_we", 32'(we_vec()), 32'h1F);
    check("br_lu_fl", 32'(fl_vec()), 32'h6);
    tick();
    clear_inputs();
    #1;
    check("br_lu_stall", 32'(stall_cnt), 32'd2);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst2_stall", 32'(stall_cnt), 32'd0);

    // three wait cycles with a pending branch, released on the fourth
    pif.mem_access = 1'b1; pif.dmem_ready = 1'b0; pif.ex_branch_taken = 1'b1;
    #1;
    check("mw1_we", 32'(we_vec()), 32'h00);
    check("mw1_fl", 32'(fl_vec()), 32'h1);
    check("mw1_valid", 32'(pif.dmem_valid), 32'd1);
    tick();
    check("mw2_we", 32'(we_vec()), 32'h00);
    check("mw2_fl", 32'(fl_vec()), 32'h1);
    tick();
    check("mw3_we", 32'(we_vec()), 32'h00);
    tick();
    pif.dmem_ready = 1'b1;
    #1;
    check("mw_rel_we", 32'(we_vec()), 32'h1F);
    check("mw_rel_fl", 32'(fl_vec()), 32'h6);
    check("mw_stall", 32'(stall_cnt), 32'd3);
    tick();
    pif.ex_branch_taken = 1'b0;
    #1;
    check("zero_wait_we", 32'(we_vec()), 32'h1F);
    check("zero_wait_fl", 32'(fl_vec()), 32'h0);
    tick();
    check("zero_wait_stall", 32'(stall_cnt), 32'd3);

    // timeout: 16 frozen cycles then ERROR, counter saturates at 4'hF
    pif.dmem_ready = 1'b0;
    #1;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("to_we_%0d", i), 32'(we_vec()), 32'h00);
      check($sformatf("to_err_%0d", i), 32'(err), 32'd0);
      tick();
    end
    check("err_set", 32'(err), 32'd1);
    check("err_valid", 32'(pif.dmem_valid), 32'd0);
    check("err_we", 32'(we_vec()), 32'h00);
    check("err_fl", 32'(fl_vec()), 32'h0);
    check("sat_stall", 32'(stall_cnt), 32'hF);
    pif.dmem_ready = 1'b1;
    tick();
    check("err_sticky", 32'(err), 32'd1);
    check("sat_hold", 32'(stall_cnt), 32'hF);

    // one-cycle reset out of ERROR
    pif.dmem_ready = 1'b0;
    reset = 1'b1;
    #1;
    check("rst_err_we", 32'(we_vec()), 32'h1F);
    check("rst_err_fl", 32'(fl_vec()), 32'h0);
    tick();
    reset = 1'b0;
    #1;
    check("post_rst_err", 32'(err), 32'd0);
    check("post_rst_stall", 32'(stall_cnt), 32'd0);
    check("post_rst_valid", 32'(pif.dmem_valid), 32'd1);
    check("post_rst_fl", 32'(fl_vec()), 32'h1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
